writeback_unit: RTL and testbench

//  Write-side master for the 32x32 integer register file: accepts ALU results and data-memory

---
 rtl/rv32_wb_pkg.sv | 19 +
 rtl/writeback_unit_load_align.sv | 41 ++++
 rtl/writeback_unit.sv | 136 +++++++++++++
 tb/tb_writeback_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_wb_pkg.sv
// Shared definitions for the register-file writeback path: RV32I load funct3 codes and the
// {rd, data} item carried through the skid buffer and output stage.
package rv32_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_RD_W   = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_item_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: picks the addressed byte/half lane of a raw memory word and sign- or
// zero-extends it according to the RV32I load funct3; reserved codes behave as LW.
module load_align
    import rv32_wb_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic [DataWidth-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_lane = rdata_i[7:0];
            2'd1: byte_lane = rdata_i[15:8];
            2'd2: byte_lane = rdata_i[23:16];
            2'd3: byte_lane = rdata_i[31:24];
            default: byte_lane = rdata_i[7:0];
        endcase
        // Halfword lane ignores addr_lo[0]; misaligned halves are the memory side's concern.
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(DataWidth-8){byte_lane[7]}}, byte_lane};
            F3_LH:   data_o = {{(DataWidth-16){half_lane[15]}}, half_lane};
            F3_LBU:  data_o = {{(DataWidth-8){1'b0}}, byte_lane};
            F3_LHU:  data_o = {{(DataWidth-16){1'b0}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results and aligned load data onto one registered register-file
// write port via a one-entry ALU skid buffer. Define WB_BYPASS_EN to add decode bypass/stall ports.
module writeback_unit
    import rv32_wb_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int RegAddress = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: an item transfers in any cycle where valid && ready at the rising edge;
    // ready does not depend on valid, and a valid item must be held until it transfers.
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [RegAddress-1:0] alu_rd,
    input  logic [DataWidth-1:0]  alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [RegAddress-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_addr_lo,
    input  logic [DataWidth-1:0]  ld_rdata,
    output logic                  rf_write_enable,
    output logic [RegAddress-1:0] rf_write_addr,
    output logic [DataWidth-1:0]  rf_write_data,
`ifdef WB_BYPASS_EN
    input  logic [RegAddress-1:0] byp_src1,
    input  logic [RegAddress-1:0] byp_src2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DataWidth-1:0]  byp_data1,
    output logic [DataWidth-1:0]  byp_data2,
    output logic                  byp_stall,
`endif
    output logic                  busy
);

    logic                  skid_valid_q, skid_valid_d;
    logic [RegAddress-1:0] skid_rd_q,    skid_rd_d;
    logic [DataWidth-1:0]  skid_data_q,  skid_data_d;

    logic                  wr_en_q,   wr_en_d;
    logic [RegAddress-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0]  wr_data_q, wr_data_d;

    logic                  issue_valid;
    logic [RegAddress-1:0] issue_rd;
    logic [DataWidth-1:0]  issue_data;
    logic [DataWidth-1:0]  ld_aligned;

    load_align #(
        .DataWidth (DataWidth)
    ) u_load_align (
        .funct3_i  (ld_funct3),
        .addr_lo_i (ld_addr_lo),
        .rdata_i   (ld_rdata),
        .data_o    (ld_aligned)
    );

    // Both sources stall together while the skid holds an item, so it always drains first.
    assign alu_ready = !skid_valid_q;
    assign ld_ready  = !skid_valid_q;

    always_comb begin
        issue_valid  = 1'b0;
        issue_rd     = '0;
        issue_data   = '0;
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            issue_valid  = 1'b1;
            issue_rd     = skid_rd_q;
            issue_data   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (ld_valid) begin
            issue_valid = 1'b1;
            issue_rd    = ld_rd;
            issue_data  = ld_aligned;
            if (alu_valid) begin
                skid_valid_d = 1'b1;
                skid_rd_d    = alu_rd;
                skid_data_d  = alu_data;
            end
        end else if (alu_valid) begin
            issue_valid = 1'b1;
            issue_rd    = alu_rd;
            issue_data  = alu_data;
        end
    end

    // x0 is hardwired: its items complete the handshake but never strobe the write port.
    always_comb begin
        wr_en_d   = issue_valid && (issue_rd != '0);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = issue_rd;
            wr_data_d = issue_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign rf_write_enable = wr_en_q;
    assign rf_write_addr   = wr_addr_q;
    assign rf_write_data   = wr_data_q;
    assign busy            = skid_valid_q | wr_en_q;

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle; a skid-held rd is not yet visible, so stall.
    assign byp_hit1  = wr_en_q && (wr_addr_q == byp_src1) && (byp_src1 != '0);
    assign byp_hit2  = wr_en_q && (wr_addr_q == byp_src2) && (byp_src2 != '0);
    assign byp_data1 = wr_en_q ? wr_data_q : '0;
    assign byp_data2 = wr_en_q ? wr_data_q : '0;
    assign byp_stall = skid_valid_q && (skid_rd_q != '0) &&
                       ((skid_rd_q == byp_src1) || (skid_rd_q == byp_src2));
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random bench for writeback_unit; expected register writes come from an
// in-order queue of accepted items and an arithmetic model of load extension.
module tb_writeback_unit;

    import rv32_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_rdata;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_src1, byp_src2;
    logic        byp_hit1, byp_hit2, byp_stall;
    logic [31:0] byp_data1, byp_data2;
`endif

    int checks = 0;
    int errors = 0;
    // Accepted items awaiting their write, oldest first: {rd, data}.
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    writeback_unit #(
        .DataWidth  (32),
        .RegAddress (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_rd           (ld_rd),
        .ld_funct3       (ld_funct3),
        .ld_addr_lo      (ld_addr_lo),
        .ld_rdata        (ld_rdata),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
`ifdef WB_BYPASS_EN
        .byp_src1        (byp_src1),
        .byp_src2        (byp_src2),
        .byp_hit1        (byp_hit1),
        .byp_hit2        (byp_hit2),
        .byp_data1       (byp_data1),
        .byp_data2       (byp_data2),
        .byp_stall       (byp_stall),
`endif
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result from shift-and-mask arithmetic on the raw word.
    function automatic logic [31:0] la_model(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'h0000_00FF;
        h = (w >> (16 * lo[1])) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // One cycle: at the falling edge check the write expected now, then offer new inputs.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] lraw, input logic [31:0] lexp);
        logic [36:0] it;
        logic        exp_we;
        logic        exp_rdy;
        @(negedge clk);
        it     = '0;
        exp_we = 1'b0;
        if (exp_q.size() > 0) begin
            it     = exp_q.pop_front();
            exp_we = (it[36:32] != 5'd0);
        end
        exp_rdy = (exp_q.size() == 0);
        chk("wr_en", {31'd0, rf_write_enable}, {31'd0, exp_we});
        if (exp_we) begin
            chk("wr_addr", {27'd0, rf_write_addr}, {27'd0, it[36:32]});
            chk("wr_data", rf_write_data, it[31:0]);
        end
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, exp_rdy});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, exp_rdy});
        chk("busy", {31'd0, busy}, {31'd0, exp_we || !exp_rdy});
        alu_valid  = av;
        alu_rd     = ard;
        alu_data   = ad;
        ld_valid   = lv;
        ld_rd      = lrd;
        ld_funct3  = f3;
        ld_addr_lo = lo;
        ld_rdata   = lraw;
        if (exp_rdy) begin
            if (lv) exp_q.push_back({lrd, lexp});
            if (av) exp_q.push_back({ard, ad});
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] raw, input logic [31:0] exp);
        step(1'b0, 5'd0, 32'd0, 1'b1, rd, f3, lo, raw, exp);
    endtask

    initial begin
        rst        = 1'b1;
        alu_valid  = 1'b1;
        alu_rd     = 5'd5;
        alu_data   = 32'hDEAD_BEEF;
        ld_valid   = 1'b0;
        ld_rd      = 5'd0;
        ld_funct3  = 3'd0;
        ld_addr_lo = 2'd0;
        ld_rdata   = 32'd0;
`ifdef WB_BYPASS_EN
        byp_src1   = 5'd0;
        byp_src2   = 5'd0;
`endif

        // Reset holds outputs low even with an ALU item offered.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", {31'd0, rf_write_enable}, 32'd0);
        chk("rst_wr_addr", {27'd0, rf_write_addr}, 32'd0);
        chk("rst_wr_data", rf_write_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        alu_valid = 1'b0;

        // ALU write with one-cycle latency.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0);
        idle();
        idle();

        // Simultaneous load and ALU: load first, ALU drains from the skid.
        step(1'b1, 5'd4, 32'hAAAA_0000, 1'b1, 5'd3, F3_LW, 2'd0, 32'h1122_3344, 32'h1122_3344);
        idle();
        idle();
        idle();

        // Lane selection and extension.
        load(5'd9,  F3_LB,  2'd0, 32'h80FF_7F01, 32'h0000_0001);
        load(5'd10, F3_LB,  2'd1, 32'h80FF_7F01, 32'h0000_007F);
        load(5'd11, F3_LB,  2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
        load(5'd12, F3_LB,  2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
        load(5'd13, F3_LHU, 2'd2, 32'h80FF_7F01, 32'h0000_80FF);
        load(5'd14, F3_LH,  2'd2, 32'h80FF_7F01, 32'hFFFF_80FF);
        load(5'd15, F3_LH,  2'd3, 32'h80FF_7F01, 32'hFFFF_80FF);
        load(5'd16, 3'b110, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01);
        idle();

        // Write to x0 handshakes but never strobes.
        step(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0);
        idle();
        idle();

        // Reset during the skid-drain cycle drops the pending x4 write.
        step(1'b1, 5'd4, 32'hAAAA_0000, 1'b1, 5'd3, F3_LW, 2'd0, 32'h1122_3344, 32'h1122_3344);
        idle();
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wr_en", {31'd0, rf_write_enable}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();
        idle();

`ifdef WB_BYPASS_EN
        step(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0);
        idle();
        byp_src1 = 5'd7;
        byp_src2 = 5'd0;
        #1;
        chk("byp_hit1", {31'd0, byp_hit1}, 32'd1);
        chk("byp_data1", byp_data1, 32'h0000_0055);
        chk("byp_hit2", {31'd0, byp_hit2}, 32'd0);
        idle();
`endif

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic        av, lv;
            logic [4:0]  ard, lrd;
            logic [31:0] ad, raw;
            logic [2:0]  f3;
            logic [1:0]  lo;
            av  = ($urandom_range(0, 99) < 60);
            lv  = ($urandom_range(0, 99) < 50);
            ard = 5'($urandom_range(0, 31));
            lrd = 5'($urandom_range(0, 31));
            ad  = $urandom;
            raw = $urandom;
            f3  = 3'($urandom_range(0, 7));
            lo  = 2'($urandom_range(0, 3));
            step(av, ard, ad, lv, lrd, f3, lo, raw, la_model(f3, lo, raw));
        end
        idle();
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
